// File: rtl/eth_recv_mac.sv
// eth_recv_mac: MII receive MAC for the 100 Mb/s path.
// Detects preamble/SFD, assembles nibbles into bytes, parses DA/SA/type,
// filters on destination, streams payload with the FCS stripped and checks
// CRC-32 against the residue at end of frame.
// Ports:
//   mii_rx_clk, rst_n                   - PHY rx clock, async active-low reset
//   mii_rx_dv, mii_rx_er, mii_rx_data   - MII receive inputs
//   local_mac, promisc                  - address filter controls
//   des_mac, src_mac, type_length       - latched header fields
//   hdr_valid                           - header parsed and frame accepted
//   pay_data, pay_valid                 - payload byte stream (FCS removed)
//   frame_done + frame_ok, crc_err, len_err, phy_err, payload_len - status
module eth_recv_mac #(
    parameter int unsigned MAX_FRAME    = 1518,
    parameter int unsigned MIN_PREAMBLE = 2
) (
    input  logic        mii_rx_clk,
    input  logic        rst_n,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    input  logic [3:0]  mii_rx_data,
    input  logic [47:0] local_mac,
    input  logic        promisc,
    output logic [47:0] des_mac,
    output logic [47:0] src_mac,
    output logic [15:0] type_length,
    output logic        hdr_valid,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic        phy_err,
    output logic [10:0] payload_len
);
    localparam int unsigned BC_W  = 11;
    localparam int unsigned PRE_W = 4;
    localparam int unsigned DLY_W = 3;

    localparam logic [31:0]       CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]       CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]       CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [47:0]       MAC_BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [3:0]        NIB_PRE     = 4'h5;
    localparam logic [3:0]        NIB_SFD     = 4'hD;
    localparam logic [PRE_W-1:0]  PRE_SAT     = '1;
    localparam logic [BC_W-1:0]   BC_SA       = BC_W'(6);
    localparam logic [BC_W-1:0]   BC_TL       = BC_W'(12);
    localparam logic [BC_W-1:0]   BC_HDR_LAST = BC_W'(13);
    localparam logic [BC_W-1:0]   BC_MIN      = BC_W'(18);
    localparam logic [BC_W-1:0]   BC_MAX      = BC_W'(MAX_FRAME);
    localparam logic [BC_W-1:0]   BC_SAT      = BC_W'(MAX_FRAME + 1);
    localparam logic [DLY_W-1:0]  DLY_FULL    = DLY_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PRE_W-1:0]   r_pre_cnt;
    logic               r_phase;
    logic [3:0]         r_low_nib;
    logic [BC_W-1:0]    r_byte_cnt;
    logic [BC_W-1:0]    r_pay_cnt;
    logic [31:0]        r_crc;
    logic [31:0]        r_dly;
    logic [DLY_W-1:0]   r_dly_cnt;
    logic               r_phy_seen;
    logic [47:0]        r_des_mac;
    logic [47:0]        r_src_mac;
    logic [15:0]        r_type_length;
    logic               r_hdr_valid;
    logic [7:0]         r_pay_data;
    logic               r_pay_valid;
    logic               r_frame_done;
    logic               r_frame_ok;
    logic               r_crc_err;
    logic               r_len_err;
    logic               r_phy_err;
    logic [BC_W-1:0]    r_payload_len;

    logic               w_in_frame;
    logic               w_byte_done;
    logic               w_sfd;
    logic               w_frame_end;
    logic               w_hdr_last;
    logic               w_accept;
    logic [7:0]         w_byte;
    logic               w_crc_bad;
    logic               w_len_bad;

    // Reflected CRC-32 advanced by one nibble, LSB first.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign w_byte    = {mii_rx_data, r_low_nib};
    assign w_crc_bad = (r_crc != CRC_RESIDUE);
    // Short, oversize, or ending on a half byte.
    assign w_len_bad = (r_state == S_HEADER) || (r_byte_cnt < BC_MIN) ||
                       (r_byte_cnt > BC_MAX) || r_phase;

    always_ff @(posedge mii_rx_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_next_state = r_state;
        w_sfd        = 1'b0;
        w_frame_end  = 1'b0;
        w_hdr_last   = 1'b0;
        w_accept     = 1'b0;
        w_in_frame   = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
        w_byte_done  = w_in_frame && mii_rx_dv && r_phase;
        case (r_state)
            S_IDLE: begin
                if (mii_rx_dv) w_next_state = (mii_rx_data == NIB_PRE) ? S_PREAMBLE : S_DROP;
            end
            S_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    w_next_state = S_IDLE;
                end else if (mii_rx_data == NIB_PRE) begin
                    w_next_state = S_PREAMBLE;
                end else if ((mii_rx_data == NIB_SFD) && (r_pre_cnt >= PRE_W'(MIN_PREAMBLE))) begin
                    w_next_state = S_HEADER;
                    w_sfd        = 1'b1;
                end else begin
                    w_next_state = S_DROP;
                end
            end
            S_HEADER: begin
                if (!mii_rx_dv) begin
                    w_next_state = S_IDLE;
                    w_frame_end  = 1'b1;
                end else if (w_byte_done && (r_byte_cnt == BC_HDR_LAST)) begin
                    // DA bytes are complete; type byte 13 is landing this cycle.
                    w_hdr_last   = 1'b1;
                    w_accept     = (r_des_mac == local_mac) || (r_des_mac == MAC_BCAST) || promisc;
                    w_next_state = w_accept ? S_PAYLOAD : S_DROP;
                end
            end
            S_PAYLOAD: begin
                if (!mii_rx_dv) begin
                    w_next_state = S_IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            S_DROP: begin
                if (!mii_rx_dv) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: preamble count, byte assembly, header capture, FCS delay line, status.
    always_ff @(posedge mii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt     <= '0;
            r_phase       <= 1'b0;
            r_low_nib     <= '0;
            r_byte_cnt    <= '0;
            r_pay_cnt     <= '0;
            r_crc         <= CRC_INIT;
            r_dly         <= '0;
            r_dly_cnt     <= '0;
            r_phy_seen    <= 1'b0;
            r_des_mac     <= '0;
            r_src_mac     <= '0;
            r_type_length <= '0;
            r_hdr_valid   <= 1'b0;
            r_pay_data    <= '0;
            r_pay_valid   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_crc_err     <= 1'b0;
            r_len_err     <= 1'b0;
            r_phy_err     <= 1'b0;
            r_payload_len <= '0;
        end else begin
            r_hdr_valid  <= 1'b0;
            r_pay_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            if ((r_state == S_IDLE) && mii_rx_dv && (mii_rx_data == NIB_PRE)) begin
                r_pre_cnt <= PRE_W'(1);
            end else if ((r_state == S_PREAMBLE) && mii_rx_dv && (mii_rx_data == NIB_PRE) &&
                         (r_pre_cnt != PRE_SAT)) begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end

            if (w_sfd) begin
                r_byte_cnt <= '0;
                r_phase    <= 1'b0;
                r_crc      <= CRC_INIT;
                r_dly_cnt  <= '0;
                r_pay_cnt  <= '0;
                r_phy_seen <= 1'b0;
            end else if (w_in_frame && mii_rx_dv) begin
                r_crc   <= crc_nib(r_crc, mii_rx_data);
                r_phase <= ~r_phase;
                if (!r_phase)  r_low_nib  <= mii_rx_data;
                if (mii_rx_er) r_phy_seen <= 1'b1;
            end

            if (w_byte_done) begin
                if (r_byte_cnt != BC_SAT) r_byte_cnt <= r_byte_cnt + BC_W'(1);
                if (r_state == S_HEADER) begin
                    // Shift in MSB-first so byte 0 lands in the top octet.
                    if (r_byte_cnt < BC_SA)      r_des_mac     <= {r_des_mac[39:0], w_byte};
                    else if (r_byte_cnt < BC_TL) r_src_mac     <= {r_src_mac[39:0], w_byte};
                    else                         r_type_length <= {r_type_length[7:0], w_byte};
                    if (w_hdr_last && w_accept)  r_hdr_valid   <= 1'b1;
                end else if (r_byte_cnt < BC_MAX) begin
                    // 4-byte delay line: a byte leaves only when pushed out, so the FCS never does.
                    r_dly <= {r_dly[23:0], w_byte};
                    if (r_dly_cnt == DLY_FULL) begin
                        r_pay_data  <= r_dly[31:24];
                        r_pay_valid <= 1'b1;
                        r_pay_cnt   <= r_pay_cnt + BC_W'(1);
                    end else begin
                        r_dly_cnt <= r_dly_cnt + DLY_W'(1);
                    end
                end
            end

            if (w_frame_end) begin
                r_frame_done  <= 1'b1;
                r_crc_err     <= w_crc_bad;
                r_len_err     <= w_len_bad;
                r_phy_err     <= r_phy_seen;
                r_frame_ok    <= !(w_crc_bad || w_len_bad || r_phy_seen);
                r_payload_len <= r_pay_cnt;
            end
        end
    end

    assign des_mac     = r_des_mac;
    assign src_mac     = r_src_mac;
    assign type_length = r_type_length;
    assign hdr_valid   = r_hdr_valid;
    assign pay_data    = r_pay_data;
    assign pay_valid   = r_pay_valid;
    assign frame_done  = r_frame_done;
    assign frame_ok    = r_frame_ok;
    assign crc_err     = r_crc_err;
    assign len_err     = r_len_err;
    assign phy_err     = r_phy_err;
    assign payload_len = r_payload_len;

endmodule

// File: tb/tb_eth_recv_mac.sv
// Scoreboard bench for eth_recv_mac: directed frames push expected header,
// payload and status records; a monitor pops and compares on each output pulse.
module tb_eth_recv_mac;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MY_MAC  = 48'h000A_3501_FEC0;
    localparam logic [47:0] OTHER   = 48'h0011_2233_4455;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
    localparam int          NONE    = 100000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv;
    logic        er;
    logic [3:0]  data;
    logic [47:0] local_mac;
    logic        promisc;
    logic [47:0] des_mac;
    logic [47:0] src_mac;
    logic [15:0] type_length;
    logic        hdr_valid;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic        phy_err;
    logic [10:0] payload_len;

    typedef struct packed {
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] tl;
    } hdr_t;

    typedef struct packed {
        logic        ok;
        logic        crc;
        logic        len;
        logic        phy;
        logic [10:0] plen;
    } done_t;

    hdr_t        exp_hdr[$];
    logic [7:0]  exp_pay[$];
    done_t       exp_done[$];
    logic [7:0]  fb[$];
    logic [31:0] tb_crc;
    int          n_checks = 0;
    int          n_errors = 0;

    eth_recv_mac dut (
        .mii_rx_clk  (clk),
        .rst_n       (rst_n),
        .mii_rx_dv   (dv),
        .mii_rx_er   (er),
        .mii_rx_data (data),
        .local_mac   (local_mac),
        .promisc     (promisc),
        .des_mac     (des_mac),
        .src_mac     (src_mac),
        .type_length (type_length),
        .hdr_valid   (hdr_valid),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .phy_err     (phy_err),
        .payload_len (payload_len)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got an unexpected pulse, expected none", name);
    endtask

    // Bit-serial reflected CRC-32, one bit at a time.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        logic fbk;
        logic [31:0] r;
        fbk = c[0] ^ b;
        r   = c >> 1;
        if (fbk) r = r ^ 32'hEDB8_8320;
        return r;
    endfunction

    // Frame = DA, SA, type, 46 payload bytes 0x00..0x2D, FCS (LSB first).
    task automatic build_frame(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] tl);
        logic [31:0] c;
        logic [7:0]  b;
        fb.delete();
        for (int i = 5; i >= 0; i--) fb.push_back(da[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(sa[8*i +: 8]);
        fb.push_back(tl[15:8]);
        fb.push_back(tl[7:0]);
        for (int i = 0; i < 46; i++) fb.push_back(8'(i));
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < fb.size(); i++) begin
            b = fb[i];
            for (int k = 0; k < 8; k++) c = crc_bit(c, b[k]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
    endtask

    task automatic expect_frame(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] tl,
                                input int n_pay, input int flip_pay);
        hdr_t       h;
        logic [7:0] b;
        h.da = da;
        h.sa = sa;
        h.tl = tl;
        exp_hdr.push_back(h);
        for (int k = 0; k < n_pay; k++) begin
            b = 8'(k);
            if (k == flip_pay) b = b ^ 8'h01;
            exp_pay.push_back(b);
        end
    endtask

    task automatic expect_done(input logic ok, input logic c, input logic l, input logic p,
                               input int plen);
        done_t d;
        d.ok   = ok;
        d.crc  = c;
        d.len  = l;
        d.phy  = p;
        d.plen = 11'(plen);
        exp_done.push_back(d);
    endtask

    task automatic send_nib(input logic [3:0] d, input logic e);
        @(negedge clk);
        dv   = 1'b1;
        data = d;
        er   = e;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        dv   = 1'b0;
        data = 4'h0;
        er   = 1'b0;
    endtask

    // Preamble 15x5 + D, then n_bytes of fb as nibbles, then a one-cycle dv gap.
    task automatic send_frame(input int n_bytes, input int flip_nib, input int er_nib,
                              input logic extra, input int rst_nib);
        logic [7:0] b;
        logic [3:0] nib;
        tb_crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b0);
        send_nib(4'hD, 1'b0);
        for (int i = 0; i < 2 * n_bytes; i++) begin
            b   = fb[i/2];
            nib = (i % 2 == 1) ? b[7:4] : b[3:0];
            if (i == flip_nib) nib = nib ^ 4'h1;
            for (int k = 0; k < 4; k++) tb_crc = crc_bit(tb_crc, nib[k]);
            send_nib(nib, (i == er_nib));
            if (i == rst_nib) begin
                #2 rst_n = 1'b0;
            end
            if (i == rst_nib + 2) begin
                check("des_mac_in_reset", 64'(des_mac), 64'd0);
                check("payload_len_in_reset", 64'(payload_len), 64'd0);
            end
            if (i == rst_nib + 4) begin
                #2 rst_n = 1'b1;
            end
        end
        if (extra) begin
            nib = 4'h0;
            for (int k = 0; k < 4; k++) tb_crc = crc_bit(tb_crc, nib[k]);
            send_nib(nib, 1'b0);
        end
        idle_cycle();
    endtask

    // Monitor: compare every output pulse against the head of its queue.
    initial begin : monitor
        hdr_t       h;
        done_t      d;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (hdr_valid) begin
                if (exp_hdr.size() == 0) begin
                    unexpected("hdr_valid");
                end else begin
                    h = exp_hdr.pop_front();
                    check("des_mac", 64'(des_mac), 64'(h.da));
                    check("src_mac", 64'(src_mac), 64'(h.sa));
                    check("type_length", 64'(type_length), 64'(h.tl));
                end
            end
            if (pay_valid) begin
                if (exp_pay.size() == 0) begin
                    unexpected("pay_valid");
                end else begin
                    b = exp_pay.pop_front();
                    check("pay_data", 64'(pay_data), 64'(b));
                end
            end
            if (frame_done) begin
                if (exp_done.size() == 0) begin
                    unexpected("frame_done");
                end else begin
                    d = exp_done.pop_front();
                    check("frame_ok", 64'(frame_ok), 64'(d.ok));
                    check("crc_err", 64'(crc_err), 64'(d.crc));
                    check("len_err", 64'(len_err), 64'(d.len));
                    check("phy_err", 64'(phy_err), 64'(d.phy));
                    check("payload_len", 64'(payload_len), 64'(d.plen));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        dv        = 1'b0;
        er        = 1'b0;
        data      = 4'h0;
        local_mac = MY_MAC;
        promisc   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_des_mac", 64'(des_mac), 64'd0);
        check("rst_src_mac", 64'(src_mac), 64'd0);
        check("rst_type_length", 64'(type_length), 64'd0);
        check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        check("rst_pay_valid", 64'(pay_valid), 64'd0);
        check("rst_pay_data", 64'(pay_data), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_ok", 64'(frame_ok), 64'd0);
        check("rst_crc_err", 64'(crc_err), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_phy_err", 64'(phy_err), 64'd0);
        check("rst_payload_len", 64'(payload_len), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good broadcast frame.
        build_frame(BCAST, MY_MAC, 16'h0800);
        expect_frame(BCAST, MY_MAC, 16'h0800, 46, NONE);
        expect_done(1'b1, 1'b0, 1'b0, 1'b0, 46);
        send_frame(64, NONE, NONE, 1'b0, NONE);

        // Payload byte 5 low nibble flipped: all bytes out, CRC fails.
        expect_frame(BCAST, MY_MAC, 16'h0800, 46, 5);
        expect_done(1'b0, 1'b1, 1'b0, 1'b0, 46);
        send_frame(64, 38, NONE, 1'b0, NONE);

        // Foreign unicast, not promiscuous: nothing at all.
        build_frame(OTHER, MY_MAC, 16'h0800);
        send_frame(64, NONE, NONE, 1'b0, NONE);

        // Same frame, promiscuous: accepted.
        promisc = 1'b1;
        expect_frame(OTHER, MY_MAC, 16'h0800, 46, NONE);
        expect_done(1'b1, 1'b0, 1'b0, 1'b0, 46);
        send_frame(64, NONE, NONE, 1'b0, NONE);
        promisc = 1'b0;

        // Unicast to our own address.
        build_frame(MY_MAC, OTHER, 16'h86DD);
        expect_frame(MY_MAC, OTHER, 16'h86DD, 46, NONE);
        expect_done(1'b1, 1'b0, 1'b0, 1'b0, 46);
        send_frame(64, NONE, NONE, 1'b0, NONE);

        // rx_er during payload byte 10: phy_err, payload still complete.
        build_frame(BCAST, MY_MAC, 16'h0800);
        expect_frame(BCAST, MY_MAC, 16'h0800, 46, NONE);
        expect_done(1'b0, 1'b0, 1'b0, 1'b1, 46);
        send_frame(64, NONE, 48, 1'b0, NONE);

        // Truncated after 13 bytes: done with len_err, no header.
        send_frame(13, NONE, NONE, 1'b0, NONE);
        expect_done(1'b0, (tb_crc != RESIDUE), 1'b1, 1'b0, 0);

        // One trailing nibble: len_err.
        expect_frame(BCAST, MY_MAC, 16'h0800, 46, NONE);
        send_frame(64, NONE, NONE, 1'b1, NONE);
        expect_done(1'b0, (tb_crc != RESIDUE), 1'b1, 1'b0, 46);

        // Reset during payload (byte 31): 13 bytes already out, no done; next frame clean.
        expect_frame(BCAST, MY_MAC, 16'h0800, 13, NONE);
        send_frame(40, NONE, NONE, 1'b0, 63);
        expect_frame(BCAST, MY_MAC, 16'h0800, 46, NONE);
        expect_done(1'b1, 1'b0, 1'b0, 1'b0, 46);
        send_frame(64, NONE, NONE, 1'b0, NONE);

        repeat (10) @(negedge clk);
        check("hdr_queue_drained", 64'(exp_hdr.size()), 64'd0);
        check("pay_queue_drained", 64'(exp_pay.size()), 64'd0);
        check("done_queue_drained", 64'(exp_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_recv_mac.md
# eth_recv_mac

MII receive-side MAC for the 100 Mb/s Ethernet path, clocked by the PHY's 25 MHz receive clock. It detects preamble and SFD, assembles nibbles into bytes, and parses the destination MAC, source MAC and type/length fields. It filters on the destination address, streams payload bytes with the FCS removed, and checks CRC-32 internally. It is the counterpart of the MII transmit MAC and sits between the PHY and the downstream protocol decoder and payload FIFO.

## Interface
Parameters:
- MAX_FRAME, 1518: maximum frame bytes from DA through FCS; larger frames are errors.
- MIN_PREAMBLE, 2: minimum 0x5 nibbles required before SFD.

Ports:
- mii_rx_clk  in  1  PHY receive clock, 25 MHz; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mii_rx_dv  in  1  receive data valid
- mii_rx_er  in  1  receive error
- mii_rx_data  in  4  receive nibble
- local_mac  in  48  own MAC address
- promisc  in  1  1 = accept any destination
- des_mac  out  48  latched destination MAC
- src_mac  out  48  latched source MAC
- type_length  out  16  latched type/length
- hdr_valid  out  1  one-cycle pulse; header fields valid, frame accepted
- pay_data  out  8  payload byte
- pay_valid  out  1  qualifies pay_data; one cycle per byte
- frame_done  out  1  one-cycle end-of-frame pulse
- frame_ok  out  1  status, valid while frame_done is high
- crc_err  out  1  status, valid while frame_done is high
- len_err  out  1  status: fewer than 18 bytes, more than MAX_FRAME bytes, or odd nibble count
- phy_err  out  1  status: mii_rx_er was seen during the frame
- payload_len  out  11  bytes emitted on pay_data, valid while frame_done is high

## Operation
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
- IDLE: on dv=1 with nibble 0x5, set the preamble count to 1 and go to PREAMBLE. On dv=1 with any other nibble, go to DROP.
- PREAMBLE: each 0x5 nibble increments the count, which saturates. Nibble 0xD with count ≥ MIN_PREAMBLE goes to HEADER. Any other nibble goes to DROP. dv=0 goes to IDLE with no frame_done.
- Byte assembly after SFD: the first nibble is bits [3:0] and the second is bits [7:4]. The byte counter is 11 bits wide and saturates at MAX_FRAME+1.
- HEADER byte mapping: bytes 0–5 form DA, byte 0 → des_mac[47:40]. Bytes 6–11 form SA, byte 6 → src_mac[47:40]. Byte 12 → type_length[15:8] and byte 13 → type_length[7:0].
- Filter after byte 13: the frame is accepted if DA == local_mac, DA == FF:FF:FF:FF:FF:FF, or promisc=1.
  - Accepted: pulse hdr_valid and go to PAYLOAD.
  - Rejected: go to DROP. Neither hdr_valid nor frame_done is produced.
- PAYLOAD: every byte from byte 14 onward enters a 4-byte delay line. A byte is emitted only when a newer byte pushes it out, so the final 4 bytes (the FCS) are never emitted.
- Oversize: once the byte count exceeds MAX_FRAME, emission stops and len_err is set. The block then waits for dv=0.
- CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) covers every nibble after SFD, FCS included, LSB first. The frame passes when the register equals the residue 0xDEBB20E3 at dv fall.
- End of frame: dv=0 in HEADER or PAYLOAD produces frame_done and returns to IDLE.
  - frame_ok = !crc_err && !len_err && !phy_err.
  - A frame ending in HEADER has len_err=1 and hdr_valid never pulses.
- DROP: ignore all input until dv=0, then go to IDLE. No outputs are produced.
- mii_rx_er=1 while dv=1 in HEADER or PAYLOAD sets phy_err. Payload emission continues.

## Timing
- Reset: all outputs are 0, the state is IDLE, and the CRC register is 0xFFFFFFFF. Reset mid-frame discards the frame. After release, the block waits in IDLE, and the remainder of the interrupted frame goes to DROP because its nibbles are not 0x5/0xD in sequence.
- hdr_valid: pulses on the edge after the high nibble of byte 13 is sampled. des_mac, src_mac and type_length are stable from then until the next SFD.
- pay_valid: payload byte k (frame byte 14+k) is emitted on the edge after the high nibble of frame byte 18+k is sampled. Back-to-back bytes arrive every 2 cycles; there is no backpressure.
- frame_done: pulses on the edge after the first sampled dv=0. Status outputs are held until the next frame_done.
- Frames may be back-to-back with a 1-cycle dv=0 gap. IDLE must accept a new preamble on the cycle after the dv=0 sample.

## Test plan
- Broadcast DA FF:FF:FF:FF:FF:FF, SA 00:0A:35:01:FE:C0, type 0x0800, 46 payload bytes 0x00..0x2D, correct FCS, 15×0x5 + 0xD preamble → hdr_valid once with des_mac, src_mac and type_length matching; 46 pay_valid bytes 0x00..0x2D in order; frame_done with frame_ok=1 and payload_len=46.
- Same frame with one payload nibble flipped → all 46 bytes emitted; frame_done with crc_err=1 and frame_ok=0.
- DA 00:11:22:33:44:55, local_mac 00:0A:35:01:FE:C0, promisc=0 → no hdr_valid, pay_valid or frame_done. Repeat with promisc=1 → accepted with frame_ok=1.
- mii_rx_er pulsed for 1 cycle at payload byte 10 → phy_err=1, frame_ok=0, payload_len=46.
- dv dropped after 13 bytes → frame_done with len_err=1, no hdr_valid. Odd nibble count (one extra nibble) → len_err=1.
- rst_n asserted mid-payload, released, then a valid frame sent after a 1-cycle gap → the first frame produces no done and the second frame is received with frame_ok=1.
